// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the front-panel button conditioner.
// Channel indices also fix the bit order of buttons_level: {down, up, ac}.
package btn_cond_pkg;

   localparam int BTN_AC   = 0;
   localparam int BTN_UP   = 1;
   localparam int BTN_DOWN = 2;
   localparam int NUM_BTN  = 3;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_HOLD   = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw front-panel buttons in, clean press pulses and stable levels out.
// The panel side is the master; the conditioner is the slave.
interface button_conditioner_if;

   logic       btn_ac_raw;
   logic       btn_up_raw;
   logic       btn_down_raw;
   logic       button_ac;
   logic       button_up;
   logic       button_down;
   logic [2:0] buttons_level;

   modport master (
      output btn_ac_raw,
      output btn_up_raw,
      output btn_down_raw,
      input  button_ac,
      input  button_up,
      input  button_down,
      input  buttons_level
   );

   modport slave (
      input  btn_ac_raw,
      input  btn_up_raw,
      input  btn_down_raw,
      output button_ac,
      output button_up,
      output button_down,
      output buttons_level
   );

endinterface

// File: rtl/button_conditioner_debounce.sv
// One button channel: two-flop synchroniser, debounce counter and press-edge detect.
// Exposes next-cycle level and press so the parent can register its outputs without extra latency.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level_d,
   output logic press_d
);

   localparam int              CW     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Counter runs only while the synchronised input disagrees with the stable level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_TC) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel conditioner: debounced AC/up/down press pulses with hold-to-repeat on up/down
// and up/down mutual exclusion. All outputs are flops.
//
// state      | meaning
// RPT_IDLE   | released, or waiting for a fresh press
// RPT_HOLD   | press pulse sent, timing the initial repeat delay
// RPT_REPEAT | held past the delay, pulsing every repeat period
module button_conditioner
   import btn_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic                clk,
   input  logic                reset,
   button_conditioner_if.slave bus
);

   localparam int            TW        = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [TW-1:0] DELAY_TC  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_TC = TW'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0]      raw;
   logic [NUM_BTN-1:0]      level_d;
   logic [NUM_BTN-1:0]      press_d;
   logic [NUM_BTN-1:0]      buttons_level_q;
   logic                    button_ac_q;
   logic                    button_ac_d;
   logic [BTN_DOWN:BTN_UP]  rpt_pulse_q;
   logic [BTN_DOWN:BTN_UP]  rpt_pulse_d;
   logic                    both_held;

   rpt_state_e              state_q [BTN_UP:BTN_DOWN];
   rpt_state_e              state_d [BTN_UP:BTN_DOWN];
   logic [TW-1:0]           timer_q [BTN_UP:BTN_DOWN];
   logic [TW-1:0]           timer_d [BTN_UP:BTN_DOWN];

   assign raw[BTN_AC]   = bus.btn_ac_raw;
   assign raw[BTN_UP]   = bus.btn_up_raw;
   assign raw[BTN_DOWN] = bus.btn_down_raw;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .reset   (reset),
         .raw     (raw[g]),
         .level_d (level_d[g]),
         .press_d (press_d[g])
      );
   end

   assign both_held   = level_d[BTN_UP] & level_d[BTN_DOWN];
   assign button_ac_d = press_d[BTN_AC];

   // Decisions use next-cycle levels so every registered output lines up with buttons_level.
   // Both held parks both channels in idle; only a fresh press can restart them.
   always_comb begin
      for (int i = BTN_UP; i <= BTN_DOWN; i++) begin
         state_d[i]     = state_q[i];
         timer_d[i]     = timer_q[i];
         rpt_pulse_d[i] = 1'b0;
         if (!level_d[i] || both_held) begin
            state_d[i] = RPT_IDLE;
            timer_d[i] = '0;
         end else begin
            case (state_q[i])
               RPT_IDLE: begin
                  if (press_d[i]) begin
                     rpt_pulse_d[i] = 1'b1;
                     state_d[i]     = RPT_HOLD;
                     timer_d[i]     = '0;
                  end
               end
               RPT_HOLD: begin
                  if (timer_q[i] == DELAY_TC) begin
                     rpt_pulse_d[i] = 1'b1;
                     state_d[i]     = RPT_REPEAT;
                     timer_d[i]     = '0;
                  end else begin
                     timer_d[i] = timer_q[i] + TW'(1);
                  end
               end
               RPT_REPEAT: begin
                  if (timer_q[i] == PERIOD_TC) begin
                     rpt_pulse_d[i] = 1'b1;
                     timer_d[i]     = '0;
                  end else begin
                     timer_d[i] = timer_q[i] + TW'(1);
                  end
               end
               default: begin
                  state_d[i] = RPT_IDLE;
                  timer_d[i] = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buttons_level_q <= '0;
         button_ac_q     <= 1'b0;
         rpt_pulse_q     <= '0;
         for (int i = BTN_UP; i <= BTN_DOWN; i++) begin
            state_q[i] <= RPT_IDLE;
            timer_q[i] <= '0;
         end
      end else begin
         buttons_level_q <= level_d;
         button_ac_q     <= button_ac_d;
         rpt_pulse_q     <= rpt_pulse_d;
         for (int i = BTN_UP; i <= BTN_DOWN; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
         end
      end
   end

   assign bus.button_ac     = button_ac_q;
   assign bus.button_up     = rpt_pulse_q[BTN_UP];
   assign bus.button_down   = rpt_pulse_q[BTN_DOWN];
   assign bus.buttons_level = buttons_level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: scenario table, hand-written bounce/reset sequences and
// a long randomized run, all checked cycle by cycle against a behavioural model.
module tb_button_conditioner;

   localparam int DEB = 8;
   localparam int DLY = 32;
   localparam int PER = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   button_conditioner_if bif ();

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (DLY),
      .REPEAT_PERIOD   (PER)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int checks = 0;
   int errors = 0;

   // Model state: raw history (newest first), stable levels, press age per repeat channel.
   bit       hist [3][DEB+2];
   bit       m_lvl [3];
   bit       m_act [3];
   int       m_age [3];
   bit [2:0] e_pulse;
   bit [2:0] e_lvl;

   function automatic void model_step(input bit rst, input bit [2:0] raw);
      bit rise [3];
      bit all_diff;
      if (rst) begin
         for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < DEB + 2; k++) hist[ch][k] = 1'b0;
            m_lvl[ch] = 1'b0;
            m_act[ch] = 1'b0;
            m_age[ch] = 0;
         end
         e_pulse = '0;
         e_lvl   = '0;
         return;
      end
      for (int ch = 0; ch < 3; ch++) begin
         rise[ch] = 1'b0;
         for (int k = DEB + 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
         hist[ch][0] = raw[ch];
         // the two newest samples are still inside the synchroniser
         all_diff = 1'b1;
         for (int k = 2; k < DEB + 2; k++) if (hist[ch][k] == m_lvl[ch]) all_diff = 1'b0;
         if (all_diff) begin
            m_lvl[ch] = !m_lvl[ch];
            rise[ch]  = m_lvl[ch];
         end
         e_lvl[ch] = m_lvl[ch];
      end
      e_pulse    = '0;
      e_pulse[0] = rise[0];
      if (m_lvl[1] && m_lvl[2]) begin
         m_act[1] = 1'b0;
         m_act[2] = 1'b0;
      end else begin
         for (int ch = 1; ch < 3; ch++) begin
            if (!m_lvl[ch]) begin
               m_act[ch] = 1'b0;
            end else if (rise[ch]) begin
               m_act[ch]   = 1'b1;
               m_age[ch]   = 0;
               e_pulse[ch] = 1'b1;
            end else if (m_act[ch]) begin
               m_age[ch]++;
               if (m_age[ch] == DLY || (m_age[ch] > DLY && (m_age[ch] - DLY) % PER == 0))
                  e_pulse[ch] = 1'b1;
            end
         end
      end
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick(input bit rst, input bit [2:0] raw);
      reset            = rst;
      bif.btn_ac_raw   = raw[0];
      bif.btn_up_raw   = raw[1];
      bif.btn_down_raw = raw[2];
      @(posedge clk);
      model_step(rst, raw);
      #1;
      checks++;
      if ({bif.button_down, bif.button_up, bif.button_ac} !== e_pulse ||
          bif.buttons_level !== e_lvl) begin
         errors++;
         $display("FAIL model t=%0t got dn/up/ac=%b%b%b lvl=%b expected dn/up/ac=%b lvl=%b",
                  $time, bif.button_down, bif.button_up, bif.button_ac, bif.buttons_level,
                  e_pulse, e_lvl);
      end
      checks++;
      if (bif.button_up === 1'b1 && bif.button_down === 1'b1) begin
         errors++;
         $display("FAIL excl t=%0t got up=1 down=1 expected not both", $time);
      end
   endtask

   task automatic preamble();
      tick(1'b1, 3'b000);
      tick(1'b1, 3'b000);
      for (int i = 0; i < 3; i++) tick(1'b0, 3'b000);
   endtask

   typedef struct {
      string name;
      int    ac_on, ac_off, up_on, up_off, dn_on, dn_off;
      int    run_len;
      int    n_ac, n_up, n_dn;
      int    f_ac, f_up, f_dn;
      int    l_up;
      int    lv_ac, lv_up;
   } vec_t;

   vec_t vecs [7];

   task automatic run_vec(input vec_t v);
      int       n [3];
      int       first [3];
      int       lvlc [3];
      int       last_up;
      bit [2:0] raw;
      bit [2:0] p;
      for (int ch = 0; ch < 3; ch++) begin
         n[ch] = 0; first[ch] = -1; lvlc[ch] = 0;
      end
      last_up = -1;
      preamble();
      for (int c = 0; c < v.run_len; c++) begin
         raw[0] = (c >= v.ac_on && c < v.ac_off);
         raw[1] = (c >= v.up_on && c < v.up_off);
         raw[2] = (c >= v.dn_on && c < v.dn_off);
         tick(1'b0, raw);
         p = {bif.button_down, bif.button_up, bif.button_ac};
         for (int ch = 0; ch < 3; ch++) begin
            if (p[ch]) begin
               n[ch]++;
               if (first[ch] < 0) first[ch] = c + 1;
               if (ch == 1) last_up = c + 1;
            end
            if (bif.buttons_level[ch]) lvlc[ch]++;
         end
      end
      chk({v.name, ".n_ac"},    n[0],     v.n_ac);
      chk({v.name, ".n_up"},    n[1],     v.n_up);
      chk({v.name, ".n_dn"},    n[2],     v.n_dn);
      chk({v.name, ".first_ac"}, first[0], v.f_ac);
      chk({v.name, ".first_up"}, first[1], v.f_up);
      chk({v.name, ".first_dn"}, first[2], v.f_dn);
      chk({v.name, ".last_up"}, last_up,  v.l_up);
      chk({v.name, ".lvl_ac"},  lvlc[0],  v.lv_ac);
      chk({v.name, ".lvl_up"},  lvlc[1],  v.lv_up);
   endtask

   initial begin
      int       up_cyc [$];
      int       exp_rst [9];
      int       n_b, f_b, prob;
      bit [2:0] r;

      bif.btn_ac_raw   = 1'b0;
      bif.btn_up_raw   = 1'b0;
      bif.btn_down_raw = 1'b0;

      //          name          ac      up      dn     run  n_ac n_up n_dn f_ac f_up f_dn l_up lv_ac lv_up
      vecs[0] = '{"idle",       0, 0,   0, 0,   0, 0,   20,  0,  0,  0, -1, -1, -1, -1,   0,   0};
      vecs[1] = '{"ac_press",   0, 40,  0, 0,   0, 0,   60,  1,  0,  0, 10, -1, -1, -1,  40,   0};
      vecs[2] = '{"up_hold",    0, 0,   0, 100, 0, 0,  130,  0, 10,  0, -1, 10, -1, 106,  0, 100};
      vecs[3] = '{"dn_hold",    0, 0,   0, 0,   0, 50,  80,  0,  0,  4, -1, -1, 10, -1,   0,   0};
      vecs[4] = '{"up_dn_both", 0, 0,   0, 121, 0, 60, 150,  0,  0,  0, -1, -1, -1, -1,   0, 121};
      vecs[5] = '{"ac_up",      0, 20,  0, 20,  0, 0,   40,  1,  1,  0, 10, 10, -1, 10,  20,  20};
      vecs[6] = '{"up_then_dn", 0, 0,   0, 40, 20, 60,  90,  0,  1,  0, -1, 10, -1, 10,   0,  40};

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Bounce: 3-high/3-low toggling never debounces; the settled press lands 10 cycles later.
      preamble();
      n_b = 0; f_b = -1;
      for (int c = 0; c < 80; c++) begin
         r = 3'b000;
         r[1] = (c < 30) ? ((c / 3) % 2 == 0) : (c < 60);
         tick(1'b0, r);
         if (bif.button_up) begin
            n_b++;
            if (f_b < 0) f_b = c + 1;
         end
      end
      chk("bounce.n_up", n_b, 1);
      chk("bounce.first_up", f_b, 40);

      // Reset mid-hold: pulse stream restarts as a fresh press after reset release.
      exp_rst = '{10, 42, 50, 62, 94, 102, 110, 118, 126};
      preamble();
      up_cyc.delete();
      for (int c = 0; c < 140; c++) begin
         tick(c == 50 || c == 51, {1'b0, c < 120, 1'b0});
         if (bif.button_up) up_cyc.push_back(c + 1);
         if (c + 1 == 51 || c + 1 == 52)
            chk("rst_clear", int'({bif.button_down, bif.button_up, bif.button_ac, bif.buttons_level}), 0);
      end
      chk("rst.n_up", up_cyc.size(), 9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("rst.pulse%0d", i), (i < up_cyc.size()) ? up_cyc[i] : -1, exp_rst[i]);

      // Randomized: mixed toggle densities, occasional reset, model checked every cycle.
      preamble();
      r = 3'b000;
      prob = 5;
      for (int i = 0; i < 6000; i++) begin
         if (i % 400 == 0) prob = (i % 1200 == 0) ? 1 : ((i % 800 == 0) ? 25 : 5);
         for (int ch = 0; ch < 3; ch++)
            if ($urandom_range(0, 99) < prob) r[ch] = ~r[ch];
         tick($urandom_range(0, 999) == 0, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-panel input stage that sits directly upstream of the AC controller. It takes the three raw, bouncing, asynchronous push-buttons (AC mode, temperature up, temperature down) and produces the clean single-cycle press pulses the controller consumes. Processing per button:
- synchronise the raw input;
- debounce it;
- detect the press edge;
- for up/down only, generate hold-to-repeat pulses.

It also enforces up/down mutual exclusion, so the controller never sees both in one cycle.

Parameters:
DEBOUNCE_CYCLES, 8, consecutive synchronised cycles an input must differ from its stable level before the stable level flips (>=2)
REPEAT_DELAY, 32, cycles from initial up/down press pulse to first auto-repeat pulse (>=2)
REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses (>=2)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous reset, active-high
btn_ac_raw  input  1  raw AC mode button, asynchronous, may bounce
btn_up_raw  input  1  raw temperature-up button, asynchronous, may bounce
btn_down_raw  input  1  raw temperature-down button, asynchronous, may bounce
button_ac  output  1  one-cycle pulse per debounced AC press, no repeat
button_up  output  1  one-cycle pulse per debounced up press plus auto-repeats
button_down  output  1  one-cycle pulse per debounced down press plus auto-repeats
buttons_level  output  3  debounced stable levels {down, up, ac}

Behaviour:
- Reset: one cycle of reset is sufficient. On reset, all synchroniser flops, stable levels, debounce counters, repeat timers and outputs are 0, and every repeat FSM goes to RPT_IDLE.
- Synchroniser: two flops per input. Nothing else samples the raw inputs.
- Debounce, per channel:
  - Counter increments each cycle the synchronised value differs from the stable level, and clears on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes the synchronised value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Press pulse: asserted in the same cycle the stable level first reads 1. Latency from the first raw-high cycle (no further bounce) to the pulse is DEBOUNCE_CYCLES+2 cycles.
- Release: a stable 1->0 transition takes the same latency and produces no pulse.
- Repeat FSM (up and down channels, independent instances):
  - RPT_IDLE: on a press pulse, emit it and go to RPT_HOLD with timer=0.
  - RPT_HOLD: timer increments each cycle. When timer==REPEAT_DELAY-1, emit a pulse, go to RPT_REPEAT, timer=0.
  - RPT_REPEAT: when timer==REPEAT_PERIOD-1, emit a pulse and set timer=0.
  - Stable level 0 in any state: go to RPT_IDLE with no pulse.
  - Timer width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Mutual exclusion:
  - While up and down stable levels are both 1, button_up and button_down are forced to 0 and both FSMs are held in RPT_IDLE.
  - If the up and down press pulses coincide, both are dropped.
  - After one of the two is released, the other does not resume; a fresh press is required.
- AC channel is independent of up/down. Coincident AC and up (or down) pulses both pass.
- Outputs are registered. button_up and button_down are never 1 in the same cycle.
- Reset mid-operation: the outputs clear on the reset cycle. A button held through reset release is treated as a new press, with the pulse DEBOUNCE_CYCLES+2 cycles after the first non-reset cycle.

Decomposition:
- Shared package btn_cond_pkg:
  - repeat FSM enum: RPT_IDLE, RPT_HOLD, RPT_REPEAT;
  - index constants BTN_AC=0, BTN_UP=1, BTN_DOWN=2.
- Sub-module button_debounce (synchroniser + debounce counter + press-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- Repeat FSM and mutual-exclusion logic stay in the top module.

Test Plan:
All cases use the default parameters; cycle 0 is the first raw-high cycle.
1. Reset, raw inputs 0 for 20 cycles -> all outputs and buttons_level stay 0.
2. btn_ac_raw high for cycles 0-39, then low -> single button_ac pulse at cycle 10; buttons_level[0] high cycles 10-49; no pulse on release; no repeat.
3. btn_up_raw toggles every 3 cycles for 30 cycles, then held high from cycle t -> no pulse during the bounce; exactly one button_up pulse at t+10.
4. btn_up_raw high for cycles 0-99 -> button_up pulses at 10, 42, 50, 58, 66, 74, 82, 90, 98, 106 (10 total); none after the stable level drops at 110.
5. btn_up_raw and btn_down_raw high together for cycles 0-59, then down released with up held to cycle 120 -> zero pulses on both outputs for the entire run.
6. btn_up_raw held; reset high cycles 50-51 -> outputs 0 during reset; button_up pulse at 62, first repeat at 94.
